wb_stage: RTL and testbench
===========================

# wb_stage

Write-back pipeline stage of the five-stage MIPS core: the initiator that drives the register file's write port. Captures the retiring instruction from the MEM stage, extends load data, selects the write-back value, and presents a single-shot register write plus PC for the commit trace. Also exports a forwarding tap and a retired-instruction counter.

## Interface
- No parameters; widths fixed: 32-bit data/PC, 5-bit register index.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `m_valid` in 1: MEM stage holds a real instruction.
- `m_pc` in 32: PC of that instruction.
- `m_reg_write` in 1: instruction writes a register.
- `m_dst` in 5: destination register index.
- `m_wb_sel` in 2: 0 = ALU result, 1 = load data, 2 = PC+8 (link); 3 is reserved and treated as 0.
- `m_ld_type` in 3: 0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu; 5–7 treated as lw.
- `m_alu_res` in 32: ALU result; also the load address.
- `m_mem_rdata` in 32: aligned data-memory word, stable before the edge.
- `stall` in 1: hold the W register.
- `flush` in 1: load a bubble into W.
- `w_pc` out 32: PC of the W instruction.
- `w_reg_write` out 1: register write strobe.
- `w_dst` out 5: write index.
- `w_data` out 32: write data.
- `fwd_valid` out 1: W holds a live non-zero destination.
- `fwd_dst` out 5, `fwd_data` out 32: bypass tap for the D/E stages.
- `retired` out 32: count of valid instructions that have left W.

## Operation
- Capture at each rising edge, in priority order:
  - `flush`: W becomes a bubble (valid = 0).
  - else `stall`: W holds its contents.
  - else W loads the MEM fields.
- Write-back value is computed before the register, so `w_data` is a registered output:
  - sel 0: `m_alu_res`.
  - sel 1: load-extended `m_mem_rdata`.
  - sel 2: `m_pc + 32'd8`, with 32-bit wrap.
- Load extension uses address `a = m_alu_res[1:0]`:
  - lb/lbu: byte `a`, little-endian (byte 0 = bits 7:0); sign-extended for lb, zero-extended for lbu.
  - lh/lhu: half `a[1]`; `a[0]` is ignored.
  - lw: whole word; `a` is ignored.
- Write-enable is one-shot:
  - An internal `fresh` flag is set when a new instruction is loaded and cleared on any stalled cycle.
  - `w_reg_write = valid & reg_write & (dst != 0) & fresh`.
  - A stalled instruction therefore writes the register file exactly once.
- Forwarding tap:
  - `fwd_valid = valid & reg_write & (dst != 0)`, independent of `fresh`.
  - `fwd_dst = w_dst`; `fwd_data = w_data`.
- `retired` increments by 1 on each edge where W is valid and is being replaced (not stalled), flush included. It wraps 2^32−1 → 0.

## Timing
- Latency is 1 cycle from MEM fields to W outputs.
- Reset values (asynchronous, immediate): `w_pc` = 0, `w_reg_write` = 0, `w_dst` = 0, `w_data` = 0, `fwd_valid` = 0, `fwd_dst` = 0, `fwd_data` = 0, `retired` = 0, valid = 0, `fresh` = 0.
- Reset asserted mid-stall discards the held instruction; no write and no retire count.
- `stall` and `flush` together: flush wins. The held instruction still counts as retired if valid.
- `m_valid = 0` without stall or flush loads a bubble.
- A bubble drives `w_pc`, `w_dst` and `w_data` to 0.

## Structure
- Package `wb_pkg` holds:
  - `WB_ALU`, `WB_MEM`, `WB_PC8` (2-bit).
  - `LD_W`, `LD_B`, `LD_BU`, `LD_H`, `LD_HU` (3-bit).
- Sub-module `load_ext` is purely combinational: inputs `rdata`, `addr[1:0]` and `ld_type`; output is the 32-bit extended value.
- All remaining logic is the W register, the `fresh` flag and the retire counter.

## Test plan
- Reset, then:
  - ALU write: pc = 0x3000, dst = 5, sel 0, alu = 0x1234_5678. Required response one cycle later: `w_reg_write` = 1, `w_dst` = 5, `w_data` = 0x12345678, `w_pc` = 0x3000, `retired` increments on the next edge.
- Load extension with rdata = 0x80FF_7F01:
  - lb, a = 3 → 0xFFFFFF80.
  - lbu, a = 1 → 0x0000007F.
  - lh, a = 2 → 0xFFFF80FF.
  - lhu, a = 3 → 0x000080FF.
  - lw → 0x80FF7F01.
- Link write: jal at pc = 0x3FFC, dst = 31, sel 2 → `w_data` = 0x00004004. Same instruction with dst = 0 → `w_reg_write` = 0 and `fwd_valid` = 0.
- Stall for 3 cycles on a dst = 8 write:
  - `w_reg_write` is high for the first cycle only.
  - `fwd_valid` stays 1 throughout.
  - `retired` increments exactly once, on release.
- Flush and stall together on a valid W → bubble next cycle, `retired` += 1, all W outputs 0.
- Reset pulse mid-cycle while a write is held → outputs go to 0 immediately without a clock edge; `retired` = 0.

Source files
------------

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Write-back select and load-type encodings for the W stage.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC8 = 2'd2;

   localparam logic [2:0] LD_W  = 3'd0;
   localparam logic [2:0] LD_B  = 3'd1;
   localparam logic [2:0] LD_BU = 3'd2;
   localparam logic [2:0] LD_H  = 3'd3;
   localparam logic [2:0] LD_HU = 3'd4;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/load_ext.sv
`default_nettype none
// ============================================================================
// Module      : load_ext
// Description : Combinational byte/half selection and extension of a load word.
// Revision    : 1.0 - initial release
// ============================================================================
module load_ext
   import wb_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [2:0]  ld_type,
   output logic [31:0] ext
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      // Little-endian lanes: byte 0 occupies bits 7:0; halfword ignores addr[0]
      w_byte = rdata[{addr, 3'b000} +: 8];
      w_half = addr[1] ? rdata[31:16] : rdata[15:0];
      ext    = rdata;
      case (ld_type)
         LD_B:    ext = {{24{w_byte[7]}}, w_byte};
         LD_BU:   ext = {24'h000000, w_byte};
         LD_H:    ext = {{16{w_half[15]}}, w_half};
         LD_HU:   ext = {16'h0000, w_half};
         default: ext = rdata;
      endcase
   end

endmodule : load_ext
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage
// Description : MIPS write-back stage: W register, one-shot RF write, bypass
//               tap and retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage
   import wb_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        m_valid,
   input  logic [31:0] m_pc,
   input  logic        m_reg_write,
   input  logic [4:0]  m_dst,
   input  logic [1:0]  m_wb_sel,
   input  logic [2:0]  m_ld_type,
   input  logic [31:0] m_alu_res,
   input  logic [31:0] m_mem_rdata,
   input  logic        stall,
   input  logic        flush,
   output logic [31:0] w_pc,
   output logic        w_reg_write,
   output logic [4:0]  w_dst,
   output logic [31:0] w_data,
   output logic        fwd_valid,
   output logic [4:0]  fwd_dst,
   output logic [31:0] fwd_data,
   output logic [31:0] retired
);

   logic [31:0] w_extData;
   logic [31:0] w_wbValue;

   logic        r_valid;
   logic        r_fresh;
   logic        r_regWrite;
   logic [31:0] r_pc;
   logic [4:0]  r_dst;
   logic [31:0] r_data;
   logic [31:0] r_retired;

   load_ext u_loadExt (
      .rdata   (m_mem_rdata),
      .addr    (m_alu_res[1:0]),
      .ld_type (m_ld_type),
      .ext     (w_extData)
   );

   always_comb begin
      w_wbValue = m_alu_res;
      case (m_wb_sel)
         WB_MEM:  w_wbValue = w_extData;
         WB_PC8:  w_wbValue = m_pc + 32'd8;
         default: w_wbValue = m_alu_res;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid    <= 1'b0;
         r_fresh    <= 1'b0;
         r_regWrite <= 1'b0;
         r_pc       <= 32'd0;
         r_dst      <= 5'd0;
         r_data     <= 32'd0;
         r_retired  <= 32'd0;
      end else begin
         // A valid instruction retires whenever it is replaced, flush included
         if (r_valid && (flush || !stall)) begin
            r_retired <= r_retired + 32'd1;
         end
         if (flush || (!stall && !m_valid)) begin
            r_valid    <= 1'b0;
            r_fresh    <= 1'b0;
            r_regWrite <= 1'b0;
            r_pc       <= 32'd0;
            r_dst      <= 5'd0;
            r_data     <= 32'd0;
         end else if (stall) begin
            r_fresh <= 1'b0;
         end else begin
            r_valid    <= 1'b1;
            r_fresh    <= 1'b1;
            r_regWrite <= m_reg_write;
            r_pc       <= m_pc;
            r_dst      <= m_dst;
            r_data     <= w_wbValue;
         end
      end
   end

   assign w_pc        = r_pc;
   assign w_dst       = r_dst;
   assign w_data      = r_data;
   assign fwd_valid   = r_valid & r_regWrite & (r_dst != 5'd0);
   assign w_reg_write = fwd_valid & r_fresh;
   assign fwd_dst     = r_dst;
   assign fwd_data    = r_data;
   assign retired     = r_retired;

endmodule : wb_stage
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage
// Description : Scoreboard bench for wb_stage with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

   logic        clk;
   logic        reset;
   logic        m_valid;
   logic [31:0] m_pc;
   logic        m_reg_write;
   logic [4:0]  m_dst;
   logic [1:0]  m_wb_sel;
   logic [2:0]  m_ld_type;
   logic [31:0] m_alu_res;
   logic [31:0] m_mem_rdata;
   logic        stall;
   logic        flush;
   logic [31:0] w_pc;
   logic        w_reg_write;
   logic [4:0]  w_dst;
   logic [31:0] w_data;
   logic        fwd_valid;
   logic [4:0]  fwd_dst;
   logic [31:0] fwd_data;
   logic [31:0] retired;

   typedef struct packed {
      logic [31:0] pc;
      logic        we;
      logic [4:0]  dst;
      logic [31:0] data;
      logic        fv;
      logic [31:0] ret;
   } exp_t;

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;

   wb_stage dut (
      .clk         (clk),
      .reset       (reset),
      .m_valid     (m_valid),
      .m_pc        (m_pc),
      .m_reg_write (m_reg_write),
      .m_dst       (m_dst),
      .m_wb_sel    (m_wb_sel),
      .m_ld_type   (m_ld_type),
      .m_alu_res   (m_alu_res),
      .m_mem_rdata (m_mem_rdata),
      .stall       (stall),
      .flush       (flush),
      .w_pc        (w_pc),
      .w_reg_write (w_reg_write),
      .w_dst       (w_dst),
      .w_data      (w_data),
      .fwd_valid   (fwd_valid),
      .fwd_dst     (fwd_dst),
      .fwd_data    (fwd_data),
      .retired     (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic chkAll(input string tag, input exp_t e);
      chk({tag, " w_pc"},        w_pc,                 e.pc);
      chk({tag, " w_reg_write"}, {31'd0, w_reg_write}, {31'd0, e.we});
      chk({tag, " w_dst"},       {27'd0, w_dst},       {27'd0, e.dst});
      chk({tag, " w_data"},      w_data,               e.data);
      chk({tag, " fwd_valid"},   {31'd0, fwd_valid},   {31'd0, e.fv});
      chk({tag, " fwd_dst"},     {27'd0, fwd_dst},     {27'd0, e.dst});
      chk({tag, " fwd_data"},    fwd_data,             e.data);
      chk({tag, " retired"},     retired,              e.ret);
   endtask

   // Monitor: compares the state produced by each edge against the scoreboard
   int vecNum = 0;
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            vecNum++;
            chkAll($sformatf("vec%0d", vecNum), e);
         end
      end
   end

   task automatic setM(input logic v, input logic [31:0] pc, input logic rw, input logic [4:0] dst,
                       input logic [1:0] sel, input logic [2:0] ld, input logic [31:0] alu,
                       input logic [31:0] rd);
      m_valid     = v;
      m_pc        = pc;
      m_reg_write = rw;
      m_dst       = dst;
      m_wb_sel    = sel;
      m_ld_type   = ld;
      m_alu_res   = alu;
      m_mem_rdata = rd;
   endtask

   // Issue one edge with the current inputs and queue the required W state
   task automatic cyc(input logic [31:0] pc, input logic we, input logic [4:0] dst,
                      input logic [31:0] data, input logic fv, input logic [31:0] ret);
      exp_t e;
      e = '{pc: pc, we: we, dst: dst, data: data, fv: fv, ret: ret};
      @(posedge clk);
      #1;
      expQ.push_back(e);
   endtask

   localparam logic [31:0] RD = 32'h80FF_7F01;

   initial begin
      reset = 1'b1;
      stall = 1'b0;
      flush = 1'b0;
      setM(1'b0, 32'd0, 1'b0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0);
      #2;
      chkAll("reset", '{pc: 32'd0, we: 1'b0, dst: 5'd0, data: 32'd0, fv: 1'b0, ret: 32'd0});
      @(negedge clk);
      reset = 1'b0;

      // ALU write and load extensions
      setM(1, 32'h3000, 1, 5'd5,  2'd0, 3'd0, 32'h1234_5678, RD); cyc(32'h3000, 1, 5'd5,  32'h1234_5678, 1, 0);
      setM(1, 32'h3004, 1, 5'd6,  2'd1, 3'd1, 32'h0000_1003, RD); cyc(32'h3004, 1, 5'd6,  32'hFFFF_FF80, 1, 1);
      setM(1, 32'h3008, 1, 5'd7,  2'd1, 3'd2, 32'h0000_1001, RD); cyc(32'h3008, 1, 5'd7,  32'h0000_007F, 1, 2);
      setM(1, 32'h300C, 1, 5'd9,  2'd1, 3'd3, 32'h0000_1002, RD); cyc(32'h300C, 1, 5'd9,  32'hFFFF_80FF, 1, 3);
      setM(1, 32'h3010, 1, 5'd10, 2'd1, 3'd4, 32'h0000_1003, RD); cyc(32'h3010, 1, 5'd10, 32'h0000_80FF, 1, 4);
      setM(1, 32'h3014, 1, 5'd11, 2'd1, 3'd0, 32'h0000_1002, RD); cyc(32'h3014, 1, 5'd11, 32'h80FF_7F01, 1, 5);
      setM(1, 32'h3018, 1, 5'd12, 2'd1, 3'd6, 32'h0000_1001, RD); cyc(32'h3018, 1, 5'd12, 32'h80FF_7F01, 1, 6);

      // Link writes, dst=0 suppression, reserved select
      setM(1, 32'h3FFC, 1, 5'd31, 2'd2, 3'd0, 32'h0000_0000, RD); cyc(32'h3FFC, 1, 5'd31, 32'h0000_4004, 1, 7);
      setM(1, 32'h3FFC, 1, 5'd0,  2'd2, 3'd0, 32'h0000_0000, RD); cyc(32'h3FFC, 0, 5'd0,  32'h0000_4004, 0, 8);
      setM(1, 32'h3020, 1, 5'd3,  2'd3, 3'd0, 32'hDEAD_BEEF, RD); cyc(32'h3020, 1, 5'd3,  32'hDEAD_BEEF, 1, 9);

      // Three-cycle stall on a dst=8 write
      setM(1, 32'h3024, 1, 5'd8,  2'd0, 3'd0, 32'hCAFE_F00D, RD); cyc(32'h3024, 1, 5'd8,  32'hCAFE_F00D, 1, 10);
      stall = 1'b1;
      setM(1, 32'h9999, 1, 5'd17, 2'd0, 3'd0, 32'h1111_1111, RD);
      for (int i = 0; i < 3; i++) cyc(32'h3024, 0, 5'd8, 32'hCAFE_F00D, 1, 10);
      stall = 1'b0;
      setM(0, 32'h4444, 1, 5'd9,  2'd0, 3'd0, 32'h2222_2222, RD); cyc(32'h0, 0, 5'd0, 32'h0, 0, 11);

      // Flush and stall together on a valid W
      setM(1, 32'h3028, 1, 5'd4,  2'd0, 3'd0, 32'h0000_0055, RD); cyc(32'h3028, 1, 5'd4,  32'h0000_0055, 1, 11);
      stall = 1'b1;
      flush = 1'b1;
      setM(1, 32'h5555, 1, 5'd6,  2'd0, 3'd0, 32'h3333_3333, RD); cyc(32'h0, 0, 5'd0, 32'h0, 0, 12);
      stall = 1'b0;
      flush = 1'b0;

      // Asynchronous reset while a write is held
      setM(1, 32'h302C, 1, 5'd13, 2'd0, 3'd0, 32'h0000_A5A5, RD); cyc(32'h302C, 1, 5'd13, 32'h0000_A5A5, 1, 12);
      stall = 1'b1;
      cyc(32'h302C, 0, 5'd13, 32'h0000_A5A5, 1, 12);
      #2;
      reset = 1'b1;
      #1;
      chkAll("async_reset", '{pc: 32'd0, we: 1'b0, dst: 5'd0, data: 32'd0, fv: 1'b0, ret: 32'd0});
      #1;
      reset = 1'b0;
      stall = 1'b0;
      setM(0, 32'h0, 0, 5'd0, 2'd0, 3'd0, 32'h0, RD);           cyc(32'h0, 0, 5'd0, 32'h0, 0, 0);
      setM(1, 32'h3030, 1, 5'd2, 2'd0, 3'd0, 32'h0000_0007, RD); cyc(32'h3030, 1, 5'd2, 32'h0000_0007, 1, 0);
      setM(0, 32'h0, 0, 5'd0, 2'd0, 3'd0, 32'h0, RD);           cyc(32'h0, 0, 5'd0, 32'h0, 0, 1);

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 20 && expQ.size() > 0; i++) @(negedge clk);
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule : tb_wb_stage
`default_nettype wire
